// File: rtl/var_arbiter_if.sv
// Bundle between var_arbiter and its requesters plus the attached self-timed var register.
//   slave  : the arbiter side (takes requests and fin lines, drives var controls and status)
//   master : the requester / var side
// Signals:
//   reqValid/reqData/reqDone  per-port write request, packed data, completion pulse
//   clrReq/clrDone            clear-to-initial-value request and completion pulse
//   varSaveReq/varRstReq      request lines to the var register
//   varDataIn                 registered data bus to the var register
//   varSaveFin/varRstFin      asynchronous completion levels from the var register
//   grantIdx/busy             last granted write port, sequencer-active flag
//   errPulse/errFlag          timeout pulse and sticky timeout flag
interface var_arbiter_if #(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumPorts = 4
) ();
  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NumPorts-1:0]       reqValid;
  logic [NumPorts*Width-1:0] reqData;
  logic [NumPorts-1:0]       reqDone;
  logic                      clrReq;
  logic                      clrDone;
  logic                      varSaveReq;
  logic                      varRstReq;
  logic [Width-1:0]          varDataIn;
  logic                      varSaveFin;
  logic                      varRstFin;
  logic [IdxW-1:0]           grantIdx;
  logic                      busy;
  logic                      errPulse;
  logic                      errFlag;

  modport slave (
    input  reqValid, reqData, clrReq, varSaveFin, varRstFin,
    output reqDone, clrDone, varSaveReq, varRstReq, varDataIn, grantIdx, busy, errPulse,
           errFlag
  );

  modport master (
    output reqValid, reqData, clrReq, varSaveFin, varRstFin,
    input  reqDone, clrDone, varSaveReq, varRstReq, varDataIn, grantIdx, busy, errPulse,
           errFlag
  );
endinterface

// File: rtl/var_arbiter.sv
// Round-robin arbiter/sequencer sharing one self-timed var register among NumPorts writers
// and one clear requester. Drives saveReq/rstReq with a minimum settle time, waits for the
// synchronized fin level, pulses per-requester completion and flags timeouts.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset
//   bus_io  var_arbiter_if slave modport (requests, var control, status)
module var_arbiter #(
  parameter int unsigned Width         = 32,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned RecoverCycles = 2,
  parameter int unsigned TimeoutCycles = 64
) (
  input logic           clk_i,
  input logic           rst_i,
  var_arbiter_if.slave  bus_io
);
  localparam int unsigned IdxW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned CntMax = (TimeoutCycles > RecoverCycles) ? TimeoutCycles
                                                                   : RecoverCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAssert, StRelease} state_e;
  typedef enum logic {OpWr, OpClr} op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [Width-1:0]    data_q, data_d;
  logic                save_req_q, save_req_d;
  logic                rst_req_q, rst_req_d;
  logic [NumPorts-1:0] req_done_q, req_done_d;
  logic                clr_done_q, clr_done_d;
  logic                err_pulse_q, err_pulse_d;
  logic                err_flag_q, err_flag_d;
  logic [1:0]          fin_sync_q, rfin_sync_q;
  logic                fin_s, rfin_s;

  // Fin levels are asynchronous; only their high level is trusted, so reset to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fin_sync_q  <= 2'b11;
      rfin_sync_q <= 2'b11;
    end else begin
      fin_sync_q  <= {fin_sync_q[0], bus_io.varSaveFin};
      rfin_sync_q <= {rfin_sync_q[0], bus_io.varRstFin};
    end
  end

  assign fin_s  = fin_sync_q[1];
  assign rfin_s = rfin_sync_q[1];

  logic [Width-1:0] port_data [NumPorts];
  for (genvar g = 0; g < NumPorts; g++) begin : g_unpack
    assign port_data[g] = bus_io.reqData[g*Width +: Width];
  end

  // First valid port at or after rr_ptr_q, wrapping upward.
  logic [IdxW-1:0] pick;
  logic            pick_valid;
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (!pick_valid && bus_io.reqValid[IdxW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = IdxW'(idx);
      end
    end
  end

  // Clear has strict priority: a pending clear blocks writes even while its fin is low.
  logic start_clr, start_wr, launch, op_fin;
  assign start_clr = bus_io.clrReq && rfin_s;
  assign start_wr  = !bus_io.clrReq && pick_valid && fin_s;
  assign op_fin    = (op_q == OpWr) ? fin_s : rfin_s;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    save_req_d  = save_req_q;
    rst_req_d   = rst_req_q;
    req_done_d  = '0;
    clr_done_d  = 1'b0;
    err_pulse_d = 1'b0;
    err_flag_d  = err_flag_q;
    launch      = 1'b0;

    case (state_q)
      StIdle: launch = 1'b1;
      StSetup: begin
        state_d = StAssert;
        cnt_d   = '0;
        if (op_q == OpWr) save_req_d = 1'b1;
        else              rst_req_d  = 1'b1;
      end
      StAssert: begin
        if ((cnt_q >= CntW'(SettleCycles - 1) && op_fin) ||
            cnt_q == CntW'(TimeoutCycles - 1)) begin
          state_d    = StRelease;
          cnt_d      = '0;
          save_req_d = 1'b0;
          rst_req_d  = 1'b0;
          if (op_q == OpWr) req_done_d = NumPorts'(1) << grant_q;
          else              clr_done_d = 1'b1;
          // A normal completion on the timeout cycle is not an abort.
          if (!(cnt_q >= CntW'(SettleCycles - 1) && op_fin)) begin
            err_pulse_d = 1'b1;
            err_flag_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_q >= CntW'(RecoverCycles - 1)) begin
          state_d = StIdle;
          launch  = 1'b1;  // back-to-back grant on the edge RELEASE ends
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      if (start_clr) begin
        state_d = StSetup;
        op_d    = OpClr;
      end else if (start_wr) begin
        state_d  = StSetup;
        op_d     = OpWr;
        grant_d  = pick;
        data_d   = port_data[pick];
        rr_ptr_d = (32'(pick) == NumPorts - 1) ? '0 : pick + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= OpWr;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      save_req_q  <= 1'b0;
      rst_req_q   <= 1'b0;
      req_done_q  <= '0;
      clr_done_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      save_req_q  <= save_req_d;
      rst_req_q   <= rst_req_d;
      req_done_q  <= req_done_d;
      clr_done_q  <= clr_done_d;
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign bus_io.reqDone    = req_done_q;
  assign bus_io.clrDone    = clr_done_q;
  assign bus_io.varSaveReq = save_req_q;
  assign bus_io.varRstReq  = rst_req_q;
  assign bus_io.varDataIn  = data_q;
  assign bus_io.grantIdx   = grant_q;
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.errPulse   = err_pulse_q;
  assign bus_io.errFlag    = err_flag_q;
endmodule

// File: tb/tb_var_arbiter.sv
module tb_var_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;
  localparam logic [W-1:0] InitVal = 32'h1234_5678;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  var_arbiter_if #(.Width(W), .NumPorts(N)) bus ();

  var_arbiter #(
    .Width(W), .NumPorts(N), .SettleCycles(4), .RecoverCycles(2), .TimeoutCycles(64)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural var register: fin dips briefly after each request, then returns high.
  logic         save_fin_m, rst_fin_m, hold_save_low;
  logic [W-1:0] var_dout;
  always @(posedge bus.varSaveReq) begin
    save_fin_m = 1'b0;
    #3;
    var_dout   = bus.varDataIn;
    save_fin_m = 1'b1;
  end
  always @(posedge bus.varRstReq) begin
    rst_fin_m = 1'b0;
    #3;
    var_dout  = InitVal;
    rst_fin_m = 1'b1;
  end
  assign bus.varSaveFin = save_fin_m && !hold_save_low;
  assign bus.varRstFin  = rst_fin_m;

  task automatic do_reset();
    rst = 1'b1;
    bus.reqValid = '0;
    bus.clrReq   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.clrReq   = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.varSaveReq !== 1'b0) begin bad++;
      $display("FAIL reset_savereq got=%0b want=0", bus.varSaveReq); end
    total++; if (bus.varRstReq !== 1'b0) begin bad++;
      $display("FAIL reset_rstreq got=%0b want=0", bus.varRstReq); end
    total++; if (bus.reqDone !== 4'b0) begin bad++;
      $display("FAIL reset_reqdone got=%0h want=0", bus.reqDone); end
    total++; if (bus.clrDone !== 1'b0) begin bad++;
      $display("FAIL reset_clrdone got=%0b want=0", bus.clrDone); end
    total++; if (bus.busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if ({bus.errPulse, bus.errFlag} !== 2'b00) begin bad++;
      $display("FAIL reset_err got=%0b want=0", {bus.errPulse, bus.errFlag}); end
    total++; if (bus.varDataIn !== 32'h0) begin bad++;
      $display("FAIL reset_datain got=%0h want=0", bus.varDataIn); end
    total++; if (bus.grantIdx !== 2'd0) begin bad++;
      $display("FAIL reset_grant got=%0d want=0", bus.grantIdx); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int save_cnt, first_save, done_k;
    logic [3:0] done_v;
    logic [W-1:0] din0;
    logic [1:0] g0;
    logic setup_req, busy6, busy7, err_seen;
    do_reset();
    save_cnt = 0; first_save = -1; done_k = -1; done_v = '0; err_seen = 1'b0;
    busy6 = 1'b0; busy7 = 1'b1;
    bus.reqData[2*W +: W] = 32'hDEAD_BEEF;
    bus.reqValid = 4'b0100;
    @(negedge clk);  // just after grant edge E0
    din0 = bus.varDataIn; g0 = bus.grantIdx; setup_req = bus.varSaveReq;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.varSaveReq) begin
        save_cnt++;
        if (first_save < 0) first_save = k;
      end
      if (bus.reqDone != 4'b0 && done_k < 0) begin
        done_k = k; done_v = bus.reqDone; bus.reqValid = '0;
      end
      if (bus.errPulse) err_seen = 1'b1;
      if (k == 6) busy6 = bus.busy;
      if (k == 7) busy7 = bus.busy;
    end
    total++; if (din0 !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL write_datain got=%0h want=deadbeef", din0); end
    total++; if (g0 !== 2'd2) begin bad++;
      $display("FAIL write_grant got=%0d want=2", g0); end
    total++; if (setup_req !== 1'b0) begin bad++;
      $display("FAIL write_setup_req got=%0b want=0", setup_req); end
    total++; if (first_save != 1) begin bad++;
      $display("FAIL write_req_start got=%0d want=1", first_save); end
    total++; if (save_cnt != 4) begin bad++;
      $display("FAIL write_req_len got=%0d want=4", save_cnt); end
    total++; if (done_k != 5 || done_v !== 4'b0100) begin bad++;
      $display("FAIL write_done got=k%0d/%0b want=k5/0100", done_k, done_v); end
    total++; if (busy6 !== 1'b1 || busy7 !== 1'b0) begin bad++;
      $display("FAIL write_busy got=%0b%0b want=10", busy6, busy7); end
    total++; if (err_seen !== 1'b0) begin bad++;
      $display("FAIL write_err got=%0b want=0", err_seen); end
    total++; if (var_dout !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL write_var_dout got=%0h want=deadbeef", var_dout); end
  endtask

  task automatic test_rotation();
    logic [1:0] g [6];
    logic [W-1:0] d [6];
    int t [6];
    logic [3:0] dn [4];
    int n, nd;
    logic prev;
    do_reset();
    for (int i = 0; i < 6; i++) begin g[i] = '1; d[i] = '1; t[i] = 0; end
    for (int i = 0; i < 4; i++) dn[i] = '0;
    for (int i = 0; i < 4; i++) bus.reqData[i*W +: W] = 32'h1111_0000 + i;
    n = 0; nd = 0; prev = 1'b0;
    bus.reqValid = 4'hF;
    for (int k = 0; k < 50 && n < 6; k++) begin
      @(negedge clk);
      if (bus.varSaveReq && !prev) begin
        g[n] = bus.grantIdx; d[n] = bus.varDataIn; t[n] = k; n++;
      end
      if (bus.reqDone != 4'b0 && nd < 4) begin dn[nd] = bus.reqDone; nd++; end
      prev = bus.varSaveReq;
    end
    bus.reqValid = '0;
    total++; if (n != 6) begin bad++;
      $display("FAIL rot_count got=%0d want=6", n); end
    for (int j = 0; j < 6; j++) begin
      total++; if (g[j] !== 2'(j % 4)) begin bad++;
        $display("FAIL rot_grant%0d got=%0d want=%0d", j, g[j], j % 4); end
      total++; if (d[j] !== 32'h1111_0000 + 32'(j % 4)) begin bad++;
        $display("FAIL rot_data%0d got=%0h want=%0h", j, d[j], 32'h1111_0000 + j % 4); end
    end
    for (int j = 1; j < 6; j++) begin
      total++; if (t[j] - t[j-1] != 7) begin bad++;
        $display("FAIL rot_spacing%0d got=%0d want=7", j, t[j] - t[j-1]); end
    end
    for (int j = 0; j < 4; j++) begin
      total++; if (dn[j] !== 4'(1 << j)) begin bad++;
        $display("FAIL rot_done%0d got=%0b want=%0b", j, dn[j], 4'(1 << j)); end
    end
  endtask

  task automatic test_clear_priority();
    logic [4:0] ev [3];
    logic [1:0] wg [2];
    int ne, nw, rst_cnt, both;
    logic prev;
    logic [W-1:0] din_clr, dout_clr;
    do_reset();
    for (int i = 0; i < 3; i++) ev[i] = '1;
    wg[0] = '0; wg[1] = '0;
    ne = 0; nw = 0; rst_cnt = 0; both = 0; prev = 1'b0;
    din_clr = '1; dout_clr = '0;
    bus.reqData[1*W +: W] = 32'hA1A1_0001;
    bus.reqData[3*W +: W] = 32'hA3A3_0003;
    bus.clrReq   = 1'b1;
    bus.reqValid = 4'b1010;
    for (int k = 0; k < 60 && ne < 3; k++) begin
      @(negedge clk);
      if (bus.varRstReq) begin rst_cnt++; din_clr = bus.varDataIn; end
      if (bus.varRstReq && bus.varSaveReq) both++;
      if (bus.varSaveReq && !prev && nw < 2) begin wg[nw] = bus.grantIdx; nw++; end
      prev = bus.varSaveReq;
      if (bus.clrDone || bus.reqDone != 4'b0) begin
        ev[ne] = {bus.clrDone, bus.reqDone};
        ne++;
        if (bus.clrDone) begin bus.clrReq = 1'b0; dout_clr = var_dout; end
        bus.reqValid = bus.reqValid & ~bus.reqDone;
      end
    end
    bus.clrReq = 1'b0; bus.reqValid = '0;
    total++; if (ev[0] !== 5'b10000) begin bad++;
      $display("FAIL clr_first got=%0b want=10000", ev[0]); end
    total++; if (ev[1] !== 5'b00010) begin bad++;
      $display("FAIL clr_second got=%0b want=00010", ev[1]); end
    total++; if (ev[2] !== 5'b01000) begin bad++;
      $display("FAIL clr_third got=%0b want=01000", ev[2]); end
    total++; if (rst_cnt != 4) begin bad++;
      $display("FAIL clr_req_len got=%0d want=4", rst_cnt); end
    total++; if (both != 0) begin bad++;
      $display("FAIL clr_both_high got=%0d want=0", both); end
    total++; if (din_clr !== 32'h0) begin bad++;
      $display("FAIL clr_datain got=%0h want=0", din_clr); end
    total++; if (dout_clr !== InitVal) begin bad++;
      $display("FAIL clr_var_dout got=%0h want=%0h", dout_clr, InitVal); end
    total++; if (wg[0] !== 2'd1 || wg[1] !== 2'd3) begin bad++;
      $display("FAIL clr_write_order got=%0d,%0d want=1,3", wg[0], wg[1]); end
  endtask

  task automatic test_timeout();
    int hi, k2;
    logic [3:0] done_v;
    logic ep, ef, found;
    do_reset();
    hi = 0; done_v = '0; ep = 1'b0; ef = 1'b0; found = 1'b0;
    bus.reqData[0*W +: W] = 32'hC0C0_0000;
    bus.reqValid = 4'b0001;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.varSaveReq) found = 1'b1;
    end
    total++; if (!found) begin bad++;
      $display("FAIL to_start got=no_request want=request"); end
    hold_save_low = 1'b1;
    hi = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.varSaveReq) hi++;
      else begin
        done_v = bus.reqDone; ep = bus.errPulse; ef = bus.errFlag;
        break;
      end
    end
    bus.reqValid = '0;
    total++; if (hi != 64) begin bad++;
      $display("FAIL to_req_len got=%0d want=64", hi); end
    total++; if (done_v !== 4'b0001 || ep !== 1'b1 || ef !== 1'b1) begin bad++;
      $display("FAIL to_abort got=done%0b/p%0b/f%0b want=done0001/p1/f1", done_v, ep, ef); end
    @(negedge clk);
    total++; if (bus.errPulse !== 1'b0 || bus.errFlag !== 1'b1) begin bad++;
      $display("FAIL to_sticky got=p%0b/f%0b want=p0/f1", bus.errPulse, bus.errFlag); end
    hold_save_low = 1'b0;
    bus.reqData[1*W +: W] = 32'hC1C1_0001;
    bus.reqValid = 4'b0010;
    hi = 0; done_v = '0; ep = 1'b1; k2 = 0;
    for (int k = 0; k < 30 && done_v == 4'b0; k++) begin
      @(negedge clk);
      if (bus.varSaveReq) hi++;
      if (bus.reqDone != 4'b0) begin done_v = bus.reqDone; ep = bus.errPulse; end
      k2 = k;
    end
    bus.reqValid = '0;
    total++; if (done_v !== 4'b0010 || ep !== 1'b0 || hi != 4) begin bad++;
      $display("FAIL to_recover got=done%0b/p%0b/len%0d/k%0d want=done0010/p0/len4",
               done_v, ep, hi, k2); end
    total++; if (bus.errFlag !== 1'b1 || var_dout !== 32'hC1C1_0001) begin bad++;
      $display("FAIL to_after got=f%0b/%0h want=f1/c1c10001", bus.errFlag, var_dout); end
  endtask

  task automatic test_reset_mid_assert();
    logic found, done_seen;
    do_reset();
    found = 1'b0; done_seen = 1'b0;
    bus.reqData[0*W +: W] = 32'hD0D0_0000;
    bus.reqData[2*W +: W] = 32'hD2D2_0002;
    bus.reqValid = 4'b0101;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.varSaveReq) found = 1'b1;
    end
    @(negedge clk);  // second ASSERT cycle
    rst = 1'b1;
    #1;
    total++; if (bus.varSaveReq !== 1'b0 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL rma_drop got=req%0b/busy%0b want=0/0", bus.varSaveReq, bus.busy); end
    @(negedge clk);
    if (bus.reqDone != 4'b0) done_seen = 1'b1;
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.reqDone != 4'b0) done_seen = 1'b1;
      if (bus.varSaveReq) found = 1'b1;
    end
    total++; if (done_seen !== 1'b0 || bus.errFlag !== 1'b0) begin bad++;
      $display("FAIL rma_nodone got=done%0b/f%0b want=0/0", done_seen, bus.errFlag); end
    total++; if (!found || bus.grantIdx !== 2'd0 || bus.varDataIn !== 32'hD0D0_0000) begin
      bad++;
      $display("FAIL rma_regrant got=%0b/%0d/%0h want=1/0/d0d00000", found, bus.grantIdx,
               bus.varDataIn); end
    bus.reqValid = '0;
  endtask

  task automatic test_sync_gating();
    int busy_cnt, k_grant;
    do_reset();
    hold_save_low = 1'b1;
    repeat (3) @(negedge clk);
    bus.reqData[0*W +: W] = 32'hE0E0_0000;
    bus.reqValid = 4'b0001;
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.busy || bus.varSaveReq) busy_cnt++;
    end
    total++; if (busy_cnt != 0) begin bad++;
      $display("FAIL sync_gate got=%0d want=0", busy_cnt); end
    hold_save_low = 1'b0;
    k_grant = -1;
    for (int k = 1; k <= 10 && k_grant < 0; k++) begin
      @(negedge clk);
      if (bus.busy) k_grant = k;
    end
    total++; if (k_grant != 3) begin bad++;
      $display("FAIL sync_grant_lat got=%0d want=3", k_grant); end
    bus.reqValid = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    hold_save_low = 1'b0;
    save_fin_m = 1'b1; rst_fin_m = 1'b1;
    var_dout = '0;
    test_reset();
    test_write();
    test_rotation();
    test_clear_priority();
    test_timeout();
    test_reset_mid_assert();
    test_sync_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/var_arbiter.md
# var_arbiter

Clocked arbiter and sequencer sharing one self-timed `var` register among NumPorts writers plus a clear requester. It grants round-robin, drives the register's saveReq/rstReq request lines and dataIn bus, and waits for saveFin/rstFin through synchronizers. It reports per-requester completion and flags timeouts. It sits between the synchronous control logic and each `var` instance that has more than one writer.

## Interface
- Width, 32, data width; must equal the attached `var` Width
- NumPorts, 4, number of write requesters (2..16)
- SettleCycles, 4, minimum cycles varSaveReq/varRstReq stays high (≥2)
- RecoverCycles, 2, minimum low cycles between requests (≥1)
- TimeoutCycles, 64, maximum cycles in ASSERT before abort (> SettleCycles)
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  reset, asynchronous and active-high
- reqValid  in  NumPorts  write request per port; level, held until reqDone
- reqData  in  NumPorts*Width  port i data at [i*Width +: Width]; stable while reqValid
- reqDone  out  NumPorts  one-cycle completion pulse for the granted port
- clrReq  in  1  request to load InitialValue; level, held until clrDone
- clrDone  out  1  one-cycle completion pulse for clear
- varSaveReq  out  1  to var saveReq
- varRstReq  out  1  to var rstReq
- varDataIn  out  Width  to var dataIn; registered
- varSaveFin  in  1  from var saveFin; asynchronous
- varRstFin  in  1  from var rstFin; asynchronous
- grantIdx  out  clog2(NumPorts)  last granted write port
- busy  out  1  high in any state except IDLE
- errPulse  out  1  one-cycle pulse, coincident with the aborting done pulse
- errFlag  out  1  sticky timeout flag; cleared only by rst

## Operation
- Each of varSaveFin and varRstFin passes through its own 2-flop synchronizer (finS, rfinS). The low phase of fin is glitch-short, so it is never relied on. Completion means: the settle count has elapsed and the synced fin is high.
- FSM states: IDLE, SETUP, ASSERT, RELEASE.
- IDLE → SETUP:
  - Entered when clrReq=1, or when any reqValid=1, and the relevant synced fin is high.
  - clrReq has strict priority over writes.
  - For a write, the grant goes to the first valid port at or after rrPtr, searching upward with wrap.
  - On that edge: varDataIn ← reqData[grant], grantIdx ← grant, rrPtr ← grant+1 (wrapping). Set the op flag to WR or CLR.
  - For a clear, varDataIn and rrPtr are unchanged.
- SETUP → ASSERT: always, after 1 cycle. This gives data setup before the request edge. varSaveReq (WR) or varRstReq (CLR) goes high on entry; cnt ← 0.
- ASSERT:
  - cnt increments each cycle.
  - Leave when cnt ≥ SettleCycles-1 and the relevant synced fin = 1.
  - Also leave, as an abort, when cnt = TimeoutCycles-1.
  - On exit the request line goes low. reqDone[grantIdx] or clrDone pulses during the first RELEASE cycle. On abort, errPulse pulses with it and errFlag ← 1.
- RELEASE: holds all request lines low for RecoverCycles cycles, then → IDLE.
- varDataIn and grantIdx hold from grant until the next grant.
- If a requester drops reqValid before it is granted, the request is dropped silently. A reqValid held after reqDone is a new request, arbitrated normally, so the rotation gives other ports their turn first.
- Only one request line is ever high. The two request lines are never high in the same cycle.

## Timing
- Reset values (asynchronous): state IDLE; varSaveReq, varRstReq, reqDone, clrDone, busy, errPulse, errFlag = 0; varDataIn = 0; grantIdx = 0; rrPtr = 0; synchronizers = 1.
- Reset mid-transaction: the request line drops immediately and no done pulse is emitted. The next grant after reset follows IDLE rules with rrPtr = 0.
- Latency, edge E0 = the IDLE grant edge:
  - E1: SETUP → ASSERT, request high from E1.
  - Request high for at least SettleCycles cycles (E1..E1+SettleCycles).
  - Done pulse in the cycle after E1+SettleCycles.
  - IDLE again at E1+SettleCycles+RecoverCycles.
  - With defaults and fin already high: request high 4 cycles, done at E0+5 cycles, next grant no earlier than edge E0+7.
- Abort: the request line is high for exactly TimeoutCycles cycles, then done+errPulse.
- busy is high from the cycle after E0 through the last RELEASE cycle.

## Test plan
- Write only: port 2 valid with 0xDEADBEEF; the var model raises fin within 2 cycles → varDataIn=0xDEADBEEF from E0+1; varSaveReq high 4 cycles; reqDone=0b0100 pulse at E0+5; var dataOut=0xDEADBEEF.
- Rotation: all 4 ports valid continuously, each re-asserting after done → grant order 0,1,2,3,0,1; each transaction 7 cycles; a new grant starts on the same edge the previous RELEASE ends.
- Clear priority: clrReq plus ports 1 and 3 valid in the same cycle → varRstReq sequence and clrDone first, varDataIn unchanged; then port 1, then port 3; var dataOut = InitialValue after clrDone.
- Timeout: varSaveFin forced low after the request → varSaveReq high exactly 64 cycles, then reqDone, errPulse=1 for one cycle, errFlag=1 sticky. The next request proceeds normally once fin is high.
- Reset mid-ASSERT: rst pulsed in cycle 2 of ASSERT → varSaveReq=0 immediately, no reqDone, errFlag=0; after release, port 0 is granted ahead of a pending port 2.
- Synchronizer gating: fin held low while in IDLE with port 0 valid → no grant. Fin goes high → grant within 3 cycles.
